complex_multiplier_pipe: RTL
============================

// Module: complex_multiplier_pipe
// PURPOSE
//   Parametrised, fully pipelined complex multiplier (twiddle stage) for the SDF FFT datapath: out = in1 * in2, or in1 * conj(in2).
//   Keeps full product precision through the add, then rounds or truncates and saturates to the input format.
//   Uses a valid/ready stream interface, so a downstream stall holds data instead of dropping it.
// PARAMETERS
//   INTEGER_SIZE  8  integer bits of the signed fixed-point format (sign bit included)
//   FRACT_SIZE    8  fraction bits; W = INTEGER_SIZE+FRACT_SIZE
//   PIPE_STAGES   2  input-to-output latency in cycles; must be >= 2
//   ROUND_MODE    0  0 = truncate (floor), 1 = round half up (+2^(FRACT_SIZE-1) before the shift)
//   SATURATE      1  1 = clamp to [-2^(W-1), 2^(W-1)-1]; 0 = wrap (keep the low W bits)
// PORTS
//   clk         in   1  clock, rising edge
//   rst         in   1  synchronous reset, active-high
//   in_valid    in   1  input sample present
//   in_ready    out  1  block accepts an input this cycle
//   conj_en     in   1  per-sample: 1 = use conj(in2)
//   in1_r/in1_i in   W  signed operand 1, real and imaginary
//   in2_r/in2_i in   W  signed operand 2 (twiddle), real and imaginary
//   out_valid   out  1  output sample present
//   out_ready   in   1  downstream accepts the output
//   out_r/out_i out  W  signed result
//   out_ovf     out  1  per-sample: real or imaginary part was saturated/wrapped
//   ovf_sticky  out  1  set on any out_ovf that is handed off; cleared by rst or clr_ovf
//   clr_ovf     in   1  clears ovf_sticky; a set on the same cycle wins
// BEHAVIOUR
//   - Reset: every stage valid bit = 0; out_valid = 0; out_r, out_i = 0; out_ovf = 0; ovf_sticky = 0.
//     Samples in flight are discarded. in_ready = 1 in the first cycle after reset.
//   - Global advance: adv = ~out_valid | out_ready. All stages shift together only when adv = 1.
//     in_ready = adv (combinational). An input is accepted when in_valid & in_ready.
//   - While out_valid & ~out_ready: out_r, out_i and out_ovf are held stable. No sample is lost or duplicated.
//   - Latency: exactly PIPE_STAGES cycles from acceptance to out_valid when out_ready stays high.
//     Throughput is 1 sample per cycle.
//   - Stage 1 registers the four full 2W-bit signed products:
//     p1 = r1*r2, p2 = i1*i2, p3 = r1*i2, p4 = i1*r2.
//     conj_en negates in2_i before the multiply. Negating -2^(W-1) is done in W+1 bits, so it does not wrap.
//   - Stage 2 forms the sums in 2W+2 bits: sr = p1 - p2, si = p3 + p4 (p2 and p3 use conj-adjusted i2).
//     It then applies the rounding offset per ROUND_MODE, arithmetic-shifts right by FRACT_SIZE,
//     and saturates or wraps to W bits.
//   - Stages 3..PIPE_STAGES are pure delay registers carrying valid, data and ovf.
//   - Overflow is flagged if the shifted real or imaginary value lies outside the W-bit range.
//     The flag covers a rounding carry into overflow. The flag also asserts when SATURATE = 0.
//   - Combinational paths: in_ready depends only on out_valid and out_ready. Data and flag outputs are always registered.
//   - Simultaneous accept and handoff in the same cycle is allowed; the pipeline stays full with no bubble.
// TESTING
//   All cases use W = 16, F = 8, PIPE_STAGES = 2 unless stated.
//   1 (1.0+j0)*(0.5+j0.5): 0x0100/0x0000 x 0x0080/0x0080, out_ready = 1.
//     -> out_valid exactly 2 cycles later; out = 0x0080/0x0080; out_ovf = 0.
//   2 conj: (1+j1)*conj(1+j1), conj_en = 1 -> out = 0x0200/0x0000.
//     Same operands with conj_en = 0 -> 0x0000/0x0200.
//   3 saturation: (127+j0)*(2+j0) -> out_r = 0x7FFF, out_ovf = 1, ovf_sticky = 1.
//     (j127)*(j2) -> out_r = 0x8000. Then clr_ovf -> ovf_sticky = 0.
//   4 rounding: 0x0001 * 0x0080 (real only): ROUND_MODE = 0 -> out_r = 0x0000; ROUND_MODE = 1 -> out_r = 0x0001.
//     Also check -0x0001 * 0x0080 in both modes.
//   5 backpressure: stream 8 random samples with out_ready toggling randomly (including 3 low cycles back-to-back).
//     -> outputs match the golden model in order; held data stays stable; in_ready = 0 exactly when out_valid & ~out_ready.
//   6 reset mid-stream with 2 samples in flight: rst for 1 cycle -> out_valid = 0 on the next cycle.
//     No stale output appears; next accepted sample emerges after PIPE_STAGES cycles. Repeat with PIPE_STAGES = 4.

Source files
------------

// File: rtl/complex_multiplier_pipe_if.sv
// Stream bundle for the complex multiplier: operand input stream, result output stream, overflow status.
// Pure wiring, no latency.
// Backpressure is carried by in_ready/out_ready in the usual valid/ready sense.
interface complex_multiplier_pipe_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         conj_en;
  logic [W-1:0] in1_r;
  logic [W-1:0] in1_i;
  logic [W-1:0] in2_r;
  logic [W-1:0] in2_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_r;
  logic [W-1:0] out_i;
  logic         out_ovf;
  logic         ovf_sticky;
  logic         clr_ovf;

  // Upstream/downstream side that drives operands and consumes results
  modport master (
    output in_valid, conj_en, in1_r, in1_i, in2_r, in2_i, out_ready, clr_ovf,
    input  in_ready, out_valid, out_r, out_i, out_ovf, ovf_sticky
  );

  // Multiplier side
  modport slave (
    input  in_valid, conj_en, in1_r, in1_i, in2_r, in2_i, out_ready, clr_ovf,
    output in_ready, out_valid, out_r, out_i, out_ovf, ovf_sticky
  );
endinterface

// File: rtl/complex_multiplier_pipe.sv
// Pipelined complex multiply (twiddle stage): out = in1*in2 or in1*conj(in2), rounded/truncated then saturated or wrapped.
// Latency PIPE_STAGES cycles (>= 2), one sample per cycle.
// All stages advance together only when the output is empty or being taken; in_ready is that advance term.
module complex_multiplier_pipe #(
  parameter int INTEGER_SIZE = 8,
  parameter int FRACT_SIZE   = 8,
  parameter int PIPE_STAGES  = 2,
  parameter int ROUND_MODE   = 0,
  parameter int SATURATE     = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  complex_multiplier_pipe_if.slave bus
);

  localparam int W  = INTEGER_SIZE + FRACT_SIZE;
  // Products carry one guard bit so the conj-negated -2^(W-1) operand never wraps.
  localparam int PW = 2 * W + 1;
  // Sum width: one more bit than the products so p1 - p2 and p3 + p4 cannot overflow.
  localparam int SW = 2 * W + 2;

  localparam logic signed [SW-1:0] MAX_V = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [SW-1:0] RND_V = (ROUND_MODE != 0) ? (SW'(1) << (FRACT_SIZE - 1)) : '0;

  // ---------------------------------------------------------------- flow control
  logic adv;
  logic out_vld;
  logic handoff;

  assign adv          = ~out_vld | bus.out_ready;
  assign handoff      = out_vld & bus.out_ready;
  assign bus.in_ready = adv;

  // ---------------------------------------------------------------- stage 1: products
  logic signed [PW-1:0] r1_x, i1_x, r2_x, i2_x, i2_c;
  logic signed [PW-1:0] p1_d, p2_d, p3_d, p4_d;
  logic                 s1_vld_q;
  logic signed [PW-1:0] s1_p1_q, s1_p2_q, s1_p3_q, s1_p4_q;

  assign r1_x = {{(PW-W){bus.in1_r[W-1]}}, bus.in1_r};
  assign i1_x = {{(PW-W){bus.in1_i[W-1]}}, bus.in1_i};
  assign r2_x = {{(PW-W){bus.in2_r[W-1]}}, bus.in2_r};
  assign i2_x = {{(PW-W){bus.in2_i[W-1]}}, bus.in2_i};
  // Conjugation is a sign flip of the twiddle's imaginary part, done in the widened domain.
  assign i2_c = bus.conj_en ? -i2_x : i2_x;

  // True products fit in PW bits, so keeping the low PW bits of the product is exact.
  assign p1_d = r1_x * r2_x;
  assign p2_d = i1_x * i2_c;
  assign p3_d = r1_x * i2_c;
  assign p4_d = i1_x * r2_x;

  // Stage 1 register: capture the four partial products when the pipe advances
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s1_p1_q  <= '0;
      s1_p2_q  <= '0;
      s1_p3_q  <= '0;
      s1_p4_q  <= '0;
    end else if (adv) begin
      s1_vld_q <= bus.in_valid;
      s1_p1_q  <= p1_d;
      s1_p2_q  <= p2_d;
      s1_p3_q  <= p3_d;
      s1_p4_q  <= p4_d;
    end
  end

  // ---------------------------------------------------------------- stage 2: sum, scale, clamp
  logic signed [SW-1:0] sr_sum, si_sum, sr_sh, si_sh;
  logic [W:0]           fit_r, fit_i;
  logic [W-1:0]         s2_r_d, s2_i_d;
  logic                 s2_ovf_d;

  // Returns {ovf, value}: ovf when v lies outside the W-bit signed range.
  function automatic logic [W:0] fit_w(input logic signed [SW-1:0] v);
    logic         ovf;
    logic [W-1:0] val;
    ovf = (v > MAX_V) || (v < MIN_V);
    val = v[W-1:0];
    if (ovf && (SATURATE != 0)) begin
      val = v[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return {ovf, val};
  endfunction

  assign sr_sum = {s1_p1_q[PW-1], s1_p1_q} - {s1_p2_q[PW-1], s1_p2_q} + RND_V;
  assign si_sum = {s1_p3_q[PW-1], s1_p3_q} + {s1_p4_q[PW-1], s1_p4_q} + RND_V;
  // Arithmetic shift gives floor semantics; the rounding offset is already folded in above,
  // so a rounding carry that pushes the value out of range is caught by fit_w.
  assign sr_sh  = sr_sum >>> FRACT_SIZE;
  assign si_sh  = si_sum >>> FRACT_SIZE;

  // Stage 2 next-state: range-fit both parts and merge their overflow flags
  always_comb begin
    fit_r    = fit_w(sr_sh);
    fit_i    = fit_w(si_sh);
    s2_r_d   = fit_r[W-1:0];
    s2_i_d   = fit_i[W-1:0];
    s2_ovf_d = fit_r[W] | fit_i[W];
  end

  // ---------------------------------------------------------------- stages 2..N: result registers
  logic         st_vld_q [2:PIPE_STAGES];
  logic [W-1:0] st_r_q   [2:PIPE_STAGES];
  logic [W-1:0] st_i_q   [2:PIPE_STAGES];
  logic         st_ovf_q [2:PIPE_STAGES];

  // Result shift chain: stage 2 takes the fitted result, later stages are plain delays
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 2; k <= PIPE_STAGES; k++) begin
        st_vld_q[k] <= 1'b0;
        st_r_q[k]   <= '0;
        st_i_q[k]   <= '0;
        st_ovf_q[k] <= 1'b0;
      end
    end else if (adv) begin
      st_vld_q[2] <= s1_vld_q;
      st_r_q[2]   <= s2_r_d;
      st_i_q[2]   <= s2_i_d;
      st_ovf_q[2] <= s2_ovf_d;
      for (int k = 3; k <= PIPE_STAGES; k++) begin
        st_vld_q[k] <= st_vld_q[k-1];
        st_r_q[k]   <= st_r_q[k-1];
        st_i_q[k]   <= st_i_q[k-1];
        st_ovf_q[k] <= st_ovf_q[k-1];
      end
    end
  end

  assign out_vld = st_vld_q[PIPE_STAGES];

  // ---------------------------------------------------------------- sticky overflow
  logic ovf_sticky_q, ovf_sticky_d;

  // Sticky next-state: only overflows actually handed downstream count; a set beats a clear
  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (handoff && st_ovf_q[PIPE_STAGES]) begin
      ovf_sticky_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_sticky_d = 1'b0;
    end
  end

  // Sticky register
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky_q <= 1'b0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign bus.out_valid  = out_vld;
  assign bus.out_r      = st_r_q[PIPE_STAGES];
  assign bus.out_i      = st_i_q[PIPE_STAGES];
  assign bus.out_ovf    = st_ovf_q[PIPE_STAGES];
  assign bus.ovf_sticky = ovf_sticky_q;

endmodule
